// File: rtl/button_event_decoder_if.sv
// Button channel bundle: debounced levels in, per-channel event pulses and held level out.
interface button_event_decoder_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] debounced_signal;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;
  logic [WIDTH-1:0] long_pulse;
  logic [WIDTH-1:0] repeat_pulse;
  logic [WIDTH-1:0] held;

  modport master (
    output debounced_signal,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held
  );

  modport slave (
    input  debounced_signal,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse,
    output held
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns debounced button levels into press / release / long-press / auto-repeat pulses,
// one independent IDLE-PRESS-LONG machine per channel sharing a common tick prescaler.
module button_event_decoder #(
  parameter int WIDTH            = 1,
  parameter int TICK_CNT_MAX     = 62500,
  parameter int LONG_PRESS_TICKS = 400,
  parameter int REPEAT_TICKS     = 100
) (
  input logic clk,
  input logic rst,
  button_event_decoder_if.slave bus
);

  localparam int PRE_W     = (TICK_CNT_MAX > 1) ? $clog2(TICK_CNT_MAX) : 1;
  localparam int MAX_TICKS = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_e;

  logic [PRE_W-1:0] prescaler_q;
  logic [PRE_W-1:0] prescaler_d;
  logic             tick;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  logic [WIDTH-1:0] pressVec;
  logic [WIDTH-1:0] releaseVec;
  logic [WIDTH-1:0] longVec;
  logic [WIDTH-1:0] repeatVec;
  logic [WIDTH-1:0] heldVec;

  assign tick        = (prescaler_q == PRE_LAST);
  assign prescaler_d = tick ? '0 : prescaler_q + PRE_W'(1);
  assign rise        = bus.debounced_signal & ~prev_q;
  assign fall        = ~bus.debounced_signal & prev_q;

  // Clearing prev on reset makes a level still high afterwards look like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      prev_q      <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      prev_q      <= bus.debounced_signal;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pressEv_d;
    logic             releaseEv_d;
    logic             longEv_d;
    logic             repeatEv_d;
    logic             held_d;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             repeat_q;
    logic             held_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= pressEv_d;
        release_q <= releaseEv_d;
        long_q    <= longEv_d;
        repeat_q  <= repeatEv_d;
        held_q    <= held_d;
      end
    end

    // A release always wins over a terminal tick landing on the same edge.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          if (rise[i]) begin
            state_d = PRESS;
            cnt_d   = '0;
          end
        end
        PRESS: begin
          if (fall[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == LONG_LAST) begin
              state_d = LONG;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        LONG: begin
          if (fall[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == REP_LAST) begin
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_comb begin
      pressEv_d   = (state_q == IDLE) && rise[i];
      releaseEv_d = ((state_q == PRESS) || (state_q == LONG)) && fall[i];
      longEv_d    = (state_q == PRESS) && !fall[i] && tick && (cnt_q == LONG_LAST);
      repeatEv_d  = (state_q == LONG) && !fall[i] && tick && (cnt_q == REP_LAST);
      held_d      = (state_d != IDLE);
    end

    assign pressVec[i]   = press_q;
    assign releaseVec[i] = release_q;
    assign longVec[i]    = long_q;
    assign repeatVec[i]  = repeat_q;
    assign heldVec[i]    = held_q;
  end

  assign bus.press_pulse   = pressVec;
  assign bus.release_pulse = releaseVec;
  assign bus.long_pulse    = longVec;
  assign bus.repeat_pulse  = repeatVec;
  assign bus.held          = heldVec;

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent button channels.
REQ-002 The block SHALL have parameter TICK_CNT_MAX, default 62500, giving the tick prescaler period in clk cycles (legal range >= 2).
REQ-003 The block SHALL have parameter LONG_PRESS_TICKS, default 400, giving the ticks of continuous hold before a long-press event (legal range >= 1).
REQ-004 The block SHALL have parameter REPEAT_TICKS, default 100, giving the ticks between auto-repeat events after a long press (legal range >= 1).
REQ-005 clk  input  1  system clock; all logic is on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 debounced_signal  input  WIDTH  clean button levels from the debouncer; 1 = pressed.
REQ-008 press_pulse  output  WIDTH  one-cycle pulse per channel on press.
REQ-009 release_pulse  output  WIDTH  one-cycle pulse per channel on release.
REQ-010 long_pulse  output  WIDTH  one-cycle pulse per channel when the hold reaches LONG_PRESS_TICKS.
REQ-011 repeat_pulse  output  WIDTH  one-cycle pulse per channel every REPEAT_TICKS while held after a long press.
REQ-012 held  output  WIDTH  level per channel, 1 while the channel FSM is not IDLE.

Function
REQ-013 A single shared prescaler SHALL count 0..TICK_CNT_MAX-1 and wrap to 0; tick is asserted combinationally while the count equals TICK_CNT_MAX-1.
REQ-014 Each channel SHALL register the previous level prev[i]; rise = level & ~prev, fall = ~level & prev.
REQ-015 Each channel SHALL own an FSM with states IDLE, PRESS and LONG, plus a tick counter of width $clog2(max(LONG_PRESS_TICKS, REPEAT_TICKS)+1).
REQ-016 IDLE: on rise, go to PRESS, clear the counter and assert press_pulse for the next cycle.
REQ-017 PRESS: on tick, increment the counter; on the tick at which the counter equals LONG_PRESS_TICKS-1, go to LONG, clear the counter and assert long_pulse.
REQ-018 LONG: on tick, increment the counter; on the tick at which the counter equals REPEAT_TICKS-1, stay in LONG, clear the counter and assert repeat_pulse.
REQ-019 PRESS or LONG: on fall, go to IDLE, clear the counter and assert release_pulse; no long or repeat pulse is emitted.
REQ-020 When fall and a terminal tick coincide, fall SHALL take priority.
REQ-021 Pulse outputs SHALL be registered, high for exactly one cycle, with one cycle of latency from the clock edge at which the triggering condition is sampled.
REQ-022 held[i] SHALL be registered and SHALL equal 1 in exactly the cycles in which the channel state is PRESS or LONG.
REQ-023 A release followed by a press on consecutive edges SHALL produce release_pulse, then press_pulse one cycle later, with no pulse lost.
REQ-024 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be reported in the same cycle.
REQ-025 At most one of press_pulse, release_pulse, long_pulse and repeat_pulse SHALL be high per channel per cycle.
REQ-026 Counters SHALL never exceed their terminal value and SHALL never wrap silently.

Reset
REQ-027 While rst is high, the prescaler, all counters and prev SHALL clear to 0, all FSMs SHALL go to IDLE, and all outputs SHALL be 0 from the next cycle.
REQ-028 Reset asserted mid-hold SHALL abort the press with no release_pulse.
REQ-029 A level still high when rst deasserts SHALL be treated as a new press: press_pulse is high in the second cycle after deassertion.

Verification (TICK_CNT_MAX=4, LONG_PRESS_TICKS=3, REPEAT_TICKS=2, WIDTH=2)
REQ-030 Short press: ch0 high for 6 cycles, then low -> exactly one press_pulse[0] and one release_pulse[0]; no long_pulse; held[0] high for 6 cycles.
REQ-031 Long hold: ch0 high for 40 cycles -> press_pulse at +1, long_pulse on the 3rd tick after the press, then repeat_pulse every 8 cycles, then release_pulse; no events on ch1.
REQ-032 Coincident release: fall timed on the 3rd tick -> release_pulse only, no long_pulse, held drops.
REQ-033 Toggle: ch0 goes 1,0,1 on consecutive edges -> press, release, press pulses in consecutive cycles.
REQ-034 Reset mid-LONG: rst for 1 cycle while ch0 is held -> outputs 0, no release_pulse, fresh press_pulse after rst deasserts.
REQ-035 Both channels pressed in the same cycle -> press_pulse = 2'b11 in one cycle.
